// File: rtl/lsq_mem_pkg.sv
// Shared types and constants for the tagged variable-latency memory model.
package lsq_mem_pkg;

    localparam int ID_W   = 4;
    localparam int DATA_W = 8;
    // Wide enough for LAT_MIN up to 256 plus an 8-bit LFSR mask.
    localparam int CNT_W  = 9;

    // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef struct packed {
        logic              valid;
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [CNT_W-1:0]  cnt;
    } pend_entry_t;

endpackage

// File: rtl/lsq_lat_lfsr.sv
// 8-bit Fibonacci LFSR that steps once per enabled cycle; drives read latency jitter.
module lsq_lat_lfsr
    import lsq_mem_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en_i,
    output logic [7:0] value_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value_o = lfsr_q;

endmodule

// File: rtl/lsq_mem_model.sv
// Tagged data memory with a small pending-read table; reads snapshot data at accept
// and return out of order after a per-entry pseudo-random latency.
module lsq_mem_model
    import lsq_mem_pkg::*;
#(
    parameter int         AW        = 8,
    parameter int         DW        = DATA_W,
    parameter int         IDW       = ID_W,
    parameter int         P         = 4,
    parameter int         LAT_MIN   = 2,
    parameter int         LAT_MASK  = 3,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           rd_req,
    input  logic [AW-1:0]  rd_addr,
    input  logic [IDW-1:0] rd_id,
    output logic           rd_ready,
    input  logic           wr_req,
    input  logic [AW-1:0]  wr_addr,
    input  logic [DW-1:0]  wr_data,
    output logic           rd_resp_valid,
    output logic [IDW-1:0] rd_resp_id,
    output logic [DW-1:0]  rd_resp_data,
    output logic [7:0]     drop_cnt,
    output logic           busy
);

    localparam int         IDX_W = $clog2(P);
    localparam int         DEPTH = 1 << AW;
    localparam logic [7:0] MASK8 = 8'(LAT_MASK);

    pend_entry_t    pend_q [P];
    pend_entry_t    pend_d [P];
    logic [DW-1:0]  mem_q  [DEPTH];

    logic [P-1:0]     valid_vec;
    logic [P-1:0]     elig_vec;
    logic [IDX_W-1:0] alloc_idx;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_vld;
    logic             accept;
    logic [7:0]       lfsr_val;
    logic [CNT_W-1:0] lat_val;
    logic [DW-1:0]    rd_data_fwd;

    logic             resp_valid_q;
    logic [IDW-1:0]   resp_id_q;
    logic [DW-1:0]    resp_data_q;
    logic [7:0]       drop_q;

    genvar gi;
    generate
        for (gi = 0; gi < P; gi++) begin : g_flags
            assign valid_vec[gi] = pend_q[gi].valid;
            assign elig_vec[gi]  = pend_q[gi].valid && (pend_q[gi].cnt == '0);
        end
    endgenerate

    // rd_ready looks only at registered state, so a slot freed this edge is not yet usable.
    assign rd_ready = ~&valid_vec;
    assign busy     = |valid_vec;
    assign accept   = rd_req && rd_ready;

    lsq_lat_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rstn    (rstn),
        .en_i    (accept),
        .value_o (lfsr_val)
    );

    assign lat_val     = CNT_W'(LAT_MIN) + CNT_W'(lfsr_val & MASK8);
    assign rd_data_fwd = (wr_req && (wr_addr == rd_addr)) ? wr_data : mem_q[rd_addr];

    // Descending scan leaves the lowest free / lowest eligible index selected.
    always_comb begin
        alloc_idx = '0;
        sel_idx   = '0;
        sel_vld   = 1'b0;
        for (int i = P - 1; i >= 0; i--) begin
            if (!valid_vec[i]) begin
                alloc_idx = IDX_W'(i);
            end
            if (elig_vec[i]) begin
                sel_idx = IDX_W'(i);
                sel_vld = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < P; i++) begin
            pend_d[i] = pend_q[i];
            if (pend_q[i].valid && (pend_q[i].cnt != '0)) begin
                pend_d[i].cnt = pend_q[i].cnt - CNT_W'(1);
            end
            if (sel_vld && (sel_idx == IDX_W'(i))) begin
                pend_d[i].valid = 1'b0;
            end
            if (accept && (alloc_idx == IDX_W'(i))) begin
                pend_d[i].valid = 1'b1;
                pend_d[i].id    = rd_id;
                pend_d[i].data  = rd_data_fwd;
                pend_d[i].cnt   = lat_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < P; i++) begin
                pend_q[i] <= '0;
            end
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
            drop_q       <= '0;
        end else begin
            for (int i = 0; i < P; i++) begin
                pend_q[i] <= pend_d[i];
            end
            resp_valid_q <= sel_vld;
            if (sel_vld) begin
                resp_id_q   <= pend_q[sel_idx].id;
                resp_data_q <= pend_q[sel_idx].data;
            end
            if (rd_req && !rd_ready && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem_q[a] <= '0;
            end
        end else if (wr_req) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_resp_valid = resp_valid_q;
    assign rd_resp_id    = resp_id_q;
    assign rd_resp_data  = resp_data_q;
    assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_lsq_mem_model.sv
// Three memory-model instances (fixed latency, jittered latency, long latency) share one
// stimulus stream and are checked every cycle against a time-stamped transaction model.
module tb_lsq_mem_model;

    localparam int NI = 3;
    localparam int P  = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rd_req = 1'b0;
    logic [7:0] rd_addr = '0;
    logic [3:0] rd_id = '0;
    logic       wr_req = 1'b0;
    logic [7:0] wr_addr = '0;
    logic [7:0] wr_data = '0;

    logic [NI-1:0] rdy;
    logic [NI-1:0] vld;
    logic [NI-1:0] bsy;
    logic [3:0]    rid   [NI];
    logic [7:0]    rdata [NI];
    logic [7:0]    drop  [NI];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lsq_mem_model #(.LAT_MIN(2), .LAT_MASK(0)) u_fix (
        .clk(clk), .rstn(rstn), .rd_req(rd_req), .rd_addr(rd_addr), .rd_id(rd_id),
        .rd_ready(rdy[0]), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_resp_valid(vld[0]), .rd_resp_id(rid[0]), .rd_resp_data(rdata[0]),
        .drop_cnt(drop[0]), .busy(bsy[0]));

    lsq_mem_model #(.LAT_MIN(2), .LAT_MASK(3)) u_ooo (
        .clk(clk), .rstn(rstn), .rd_req(rd_req), .rd_addr(rd_addr), .rd_id(rd_id),
        .rd_ready(rdy[1]), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_resp_valid(vld[1]), .rd_resp_id(rid[1]), .rd_resp_data(rdata[1]),
        .drop_cnt(drop[1]), .busy(bsy[1]));

    lsq_mem_model #(.LAT_MIN(8), .LAT_MASK(3)) u_ovf (
        .clk(clk), .rstn(rstn), .rd_req(rd_req), .rd_addr(rd_addr), .rd_id(rd_id),
        .rd_ready(rdy[2]), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_resp_valid(vld[2]), .rd_resp_id(rid[2]), .rd_resp_data(rdata[2]),
        .drop_cnt(drop[2]), .busy(bsy[2]));

    // Reference model: each slot remembers the edge at which its latency expires.
    int         lat_min  [NI] = '{2, 2, 8};
    int         lat_mask [NI] = '{0, 3, 3};
    int         ecnt;
    logic [7:0] m_mem   [256];
    bit         m_valid [NI][P];
    logic [3:0] m_id    [NI][P];
    logic [7:0] m_data  [NI][P];
    int         m_due   [NI][P];
    logic [7:0] m_lfsr  [NI];
    int         m_drop  [NI];
    bit         exp_v   [NI];
    logic [3:0] exp_id  [NI];
    logic [7:0] exp_dat [NI];

    task automatic model_reset();
        ecnt = 0;
        for (int a = 0; a < 256; a++) m_mem[a] = 8'h00;
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < P; i++) m_valid[k][i] = 1'b0;
            m_lfsr[k]  = 8'hA5;
            m_drop[k]  = 0;
            exp_v[k]   = 1'b0;
            exp_id[k]  = '0;
            exp_dat[k] = '0;
        end
    endtask

    task automatic model_edge();
        int sel;
        int fr;
        bit fb;
        if (!rstn) return;
        ecnt++;
        for (int k = 0; k < NI; k++) begin
            sel = -1;
            fr  = -1;
            for (int i = 0; i < P; i++) begin
                if (fr < 0 && !m_valid[k][i]) fr = i;
                if (sel < 0 && m_valid[k][i] && m_due[k][i] < ecnt) sel = i;
            end
            exp_v[k] = 1'b0;
            if (sel >= 0) begin
                exp_v[k]   = 1'b1;
                exp_id[k]  = m_id[k][sel];
                exp_dat[k] = m_data[k][sel];
                m_valid[k][sel] = 1'b0;
            end
            if (rd_req) begin
                if (fr >= 0) begin
                    m_valid[k][fr] = 1'b1;
                    m_id[k][fr]    = rd_id;
                    m_data[k][fr]  = (wr_req && wr_addr == rd_addr) ? wr_data : m_mem[rd_addr];
                    m_due[k][fr]   = ecnt + lat_min[k] + (int'(m_lfsr[k]) & lat_mask[k]);
                    fb = m_lfsr[k][7] ^ m_lfsr[k][5] ^ m_lfsr[k][4] ^ m_lfsr[k][3];
                    m_lfsr[k] = {m_lfsr[k][6:0], fb};
                end else if (m_drop[k] < 255) begin
                    m_drop[k]++;
                end
            end
        end
        if (wr_req) m_mem[wr_addr] = wr_data;
    endtask

    task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, expv);
        end
    endtask

    task automatic compare_all();
        bit any_free;
        bit any_busy;
        for (int k = 0; k < NI; k++) begin
            any_free = 1'b0;
            any_busy = 1'b0;
            for (int i = 0; i < P; i++) begin
                if (m_valid[k][i]) any_busy = 1'b1;
                else any_free = 1'b1;
            end
            check("resp_valid", k, 32'(vld[k]), 32'(exp_v[k]));
            if (exp_v[k]) begin
                check("resp_id", k, 32'(rid[k]), 32'(exp_id[k]));
                check("resp_data", k, 32'(rdata[k]), 32'(exp_dat[k]));
            end
            check("rd_ready", k, 32'(rdy[k]), 32'(any_free));
            check("busy", k, 32'(bsy[k]), 32'(any_busy));
            check("drop_cnt", k, 32'(drop[k]), 32'(m_drop[k]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic clr();
        rd_req = 1'b0;
        wr_req = 1'b0;
    endtask

    task automatic set_rd(input logic [7:0] a, input logic [3:0] id);
        rd_req = 1'b1; rd_addr = a; rd_id = id;
    endtask

    task automatic set_wr(input logic [7:0] a, input logic [7:0] d);
        wr_req = 1'b1; wr_addr = a; wr_data = d;
    endtask

    task automatic idle(input int n);
        clr();
        for (int c = 0; c < n; c++) step();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        clr();
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < NI; k++) begin
            check("rst_valid", k, 32'(vld[k]), 32'd0);
            check("rst_busy", k, 32'(bsy[k]), 32'd0);
            check("rst_drop", k, 32'(drop[k]), 32'd0);
            check("rst_id", k, 32'(rid[k]), 32'd0);
            check("rst_data", k, 32'(rdata[k]), 32'd0);
        end
        @(posedge clk);
        #2;
        rstn = 1'b1;
    endtask

    bit   ooo_v   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] ooo_id [5] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3};
    int   nresp;

    initial begin
        model_reset();
        do_reset();
        idle(2);

        // Fixed latency: response visible after the third edge following the accept edge.
        set_wr(8'h10, 8'h3C); step(); clr();
        set_rd(8'h10, 4'd5); step(); clr();
        step(); check("fix_early1", 0, 32'(vld[0]), 32'd0);
        step(); check("fix_early2", 0, 32'(vld[0]), 32'd0);
        step();
        check("fix_valid", 0, 32'(vld[0]), 32'd1);
        check("fix_id", 0, 32'(rid[0]), 32'd5);
        check("fix_data", 0, 32'(rdata[0]), 32'h3C);
        step(); check("fix_pulse", 0, 32'(vld[0]), 32'd0);
        idle(10);

        // Same-cycle write forwarding, then overwrite before the response.
        set_wr(8'h20, 8'h77); set_rd(8'h20, 4'd2); step(); clr();
        set_wr(8'h20, 8'h11); step(); clr();
        step(); step();
        check("raw_valid", 0, 32'(vld[0]), 32'd1);
        check("raw_data", 0, 32'(rdata[0]), 32'h77);
        idle(10);

        // Out of order from seed: latencies 3,4,3,4 give a tie between entries 1 and 2.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_wr(8'(8'h30 + i), 8'(8'hA0 + i)); step();
        end
        clr();
        for (int i = 0; i < 4; i++) begin
            set_rd(8'(8'h30 + i), 4'(i)); step();
        end
        clr();
        for (int j = 0; j < 5; j++) begin
            step();
            check("ooo_valid", 1, 32'(vld[1]), 32'(ooo_v[j]));
            if (ooo_v[j]) begin
                check("ooo_id", 1, 32'(rid[1]), 32'(ooo_id[j]));
                check("ooo_data", 1, 32'(rdata[1]), 32'(8'hA0 + ooo_id[j]));
            end
        end
        idle(10);

        // Overflow: six back-to-back reads into four long-latency slots.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_wr(8'(8'h40 + i), 8'(8'hC0 + i)); step();
        end
        clr();
        for (int i = 0; i < 6; i++) begin
            if (i == 4) check("ovf_ready", 2, 32'(rdy[2]), 32'd0);
            set_rd(8'(8'h40 + i), 4'(8 + i)); step();
        end
        clr();
        check("ovf_drop", 2, 32'(drop[2]), 32'd2);
        nresp = 0;
        for (int c = 0; c < 40 && bsy[2]; c++) begin
            step();
            if (vld[2]) nresp++;
        end
        check("ovf_resp_count", 2, 32'(nresp), 32'd4);
        check("ovf_busy_end", 2, 32'(bsy[2]), 32'd0);
        idle(5);

        // Reset with reads in flight: nothing stale may come back afterwards.
        for (int i = 0; i < 3; i++) begin
            set_rd(8'(8'h40 + i), 4'(i)); step();
        end
        do_reset();
        idle(15);
        set_wr(8'h55, 8'h9E); step(); clr();
        set_rd(8'h55, 4'd7); step(); clr();
        step(); step(); step();
        check("post_rst_valid", 0, 32'(vld[0]), 32'd1);
        check("post_rst_id", 0, 32'(rid[0]), 32'd7);
        check("post_rst_data", 0, 32'(rdata[0]), 32'h9E);
        idle(10);

        // Randomized traffic on a narrow address window to provoke forwarding and contention.
        for (int c = 0; c < 400; c++) begin
            rd_req  = ($urandom_range(0, 99) < 55);
            rd_addr = 8'($urandom_range(0, 15));
            rd_id   = 4'($urandom_range(0, 15));
            wr_req  = ($urandom_range(0, 99) < 40);
            wr_addr = 8'($urandom_range(0, 15));
            wr_data = 8'($urandom_range(0, 255));
            step();
        end
        idle(30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
